// File: rtl/prim_flop_rr_wr_arb.sv
// Round-robin write arbiter in front of a single shared flop register, with a
// post-write hold-off window. Optional lock port under PRIM_FLOP_RR_WR_ARB_LOCK_EN.
module prim_flop_rr_wr_arb #(
  parameter int unsigned       NumReq     = 4,
  parameter int unsigned       Width      = 32,
  parameter logic [Width-1:0]  ResetValue = '0,
  parameter int unsigned       HoldCycles = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NumReq-1:0]           req_i,
  input  logic [NumReq*Width-1:0]     wdata_i,
`ifdef PRIM_FLOP_RR_WR_ARB_LOCK_EN
  input  logic                        lock_i,
  output logic                        locked_o,
`endif
  output logic [NumReq-1:0]           gnt_o,
  output logic [Width-1:0]            q_o,
  output logic                        wr_o,
  output logic [$clog2(NumReq)-1:0]   wr_idx_o,
  output logic                        busy_o
);

  localparam int unsigned IdxW = $clog2(NumReq);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  state_e              r_state;
  state_e              w_state_next;
  logic [7:0]          r_hold_cnt;
  logic [7:0]          w_hold_cnt_next;
  logic [IdxW-1:0]     r_ptr;
  logic [IdxW-1:0]     w_ptr_next;
  logic [Width-1:0]    r_q;
  logic                r_wr;
  logic [IdxW-1:0]     r_wr_idx;

  logic [2*NumReq-1:0] w_req_dbl;
  logic [2*NumReq-1:0] w_req_shift;
  logic [NumReq-1:0]   w_req_rot;
  logic                w_found;
  logic [IdxW-1:0]     w_off;
  logic [IdxW:0]       w_sum;
  logic [IdxW-1:0]     w_gnt_idx;
  logic                w_can_grant;
  logic                w_grant;
  logic [NumReq-1:0]   w_gnt;
  logic [Width-1:0]    w_wdata_sel;
  logic                w_locked;

`ifdef PRIM_FLOP_RR_WR_ARB_LOCK_EN
  logic r_locked;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_locked <= 1'b0;
    end else if (lock_i) begin
      r_locked <= 1'b1;
    end
  end

  assign w_locked = r_locked;
  assign locked_o = r_locked;
`else
  assign w_locked = 1'b0;
`endif

  // Rotating the doubled request vector by the pointer turns the wrap-around
  // search into a plain lowest-set-bit search.
  assign w_req_dbl   = {req_i, req_i};
  assign w_req_shift = w_req_dbl >> r_ptr;
  assign w_req_rot   = w_req_shift[NumReq-1:0];

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    w_found = 1'b0;
    w_off   = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (!w_found && w_req_rot[i]) begin
        w_found = 1'b1;
        w_off   = IdxW'(i);
      end
    end
  end

  always_comb begin
    w_sum = {1'b0, r_ptr} + {1'b0, w_off};
    if (w_sum >= (IdxW+1)'(NumReq)) begin
      w_sum = w_sum - (IdxW+1)'(NumReq);
    end
  end

  assign w_gnt_idx   = w_sum[IdxW-1:0];
  // Reset gates the grant so nothing can commit on an edge while rst_ni is low.
  assign w_can_grant = rst_ni && (r_state == ST_IDLE) && !w_locked;
  assign w_grant     = w_can_grant && w_found;

  always_comb begin
    w_gnt       = '0;
    w_wdata_sel = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      w_gnt[i] = w_grant && (w_gnt_idx == IdxW'(i));
      if (w_gnt[i]) begin
        w_wdata_sel = wdata_i[i*Width +: Width];
      end
    end
  end

  assign w_ptr_next = (w_gnt_idx == IdxW'(NumReq - 1)) ? '0 : w_gnt_idx + 1'b1;

  always_comb begin
    w_state_next    = r_state;
    w_hold_cnt_next = r_hold_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_grant && (HoldCycles > 0)) begin
          w_state_next    = ST_HOLD;
          w_hold_cnt_next = 8'(HoldCycles - 1);
        end
      end
      ST_HOLD: begin
        if (r_hold_cnt == 8'd0) begin
          w_state_next = ST_IDLE;
        end else begin
          w_hold_cnt_next = r_hold_cnt - 8'd1;
        end
      end
      default: begin
        w_state_next    = ST_IDLE;
        w_hold_cnt_next = 8'd0;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= ST_IDLE;
      r_hold_cnt <= 8'd0;
      r_ptr      <= '0;
    end else begin
      r_state    <= w_state_next;
      r_hold_cnt <= w_hold_cnt_next;
      if (w_grant) begin
        r_ptr <= w_ptr_next;
      end
    end
  end

  // NOTE: the register itself is a plain flop bank, so it does get reset to
  // ResetValue; only true RAM arrays are left without reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_q      <= ResetValue;
      r_wr     <= 1'b0;
      r_wr_idx <= '0;
    end else begin
      r_wr <= w_grant;
      if (w_grant) begin
        r_q      <= w_wdata_sel;
        r_wr_idx <= w_gnt_idx;
      end
    end
  end

  assign gnt_o    = w_gnt;
  assign q_o      = r_q;
  assign wr_o     = r_wr;
  assign wr_idx_o = r_wr_idx;
  assign busy_o   = (r_state == ST_HOLD);

  a_gnt_onehot0 : assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(gnt_o));
  a_no_gnt_in_hold : assert property (@(posedge clk_i) disable iff (!rst_ni)
    busy_o |-> (gnt_o == '0));

endmodule

// File: tb/tb_prim_flop_rr_wr_arb.sv
// Randomized bench for prim_flop_rr_wr_arb: an abstract arbitration model predicts
// grants/busy and queues expected writes; a monitor checks each write pulse.
module tb_prim_flop_rr_wr_arb;

  localparam int          N       = 4;
  localparam int          W       = 32;
  localparam int          HOLD    = 2;
  localparam logic [31:0] RST_VAL = 32'hA5A5_0000;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] wdata = '0;
  logic [N-1:0]   gnt;
  logic [W-1:0]   q;
  logic           wr;
  logic [1:0]     wr_idx;
  logic           busy;
`ifdef PRIM_FLOP_RR_WR_ARB_LOCK_EN
  logic           lock = 1'b0;
  logic           locked;
`endif

  always #5 clk = ~clk;

  prim_flop_rr_wr_arb #(
    .NumReq     (N),
    .Width      (W),
    .ResetValue (RST_VAL),
    .HoldCycles (HOLD)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .req_i    (req),
    .wdata_i  (wdata),
`ifdef PRIM_FLOP_RR_WR_ARB_LOCK_EN
    .lock_i   (lock),
    .locked_o (locked),
`endif
    .gnt_o    (gnt),
    .q_o      (q),
    .wr_o     (wr),
    .wr_idx_o (wr_idx),
    .busy_o   (busy)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         idx;
    logic [W-1:0] data;
  } wr_t;
  wr_t sb_q[$];

  // Reference model: priority pointer, remaining hold-off cycles, lock flag.
  int           m_ptr    = 0;
  int           m_hold   = 0;
  bit           m_locked = 1'b0;
  logic [W-1:0] m_q      = RST_VAL;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r);
    for (int i = 0; i < N; i++) begin
      if (r[(m_ptr + i) % N]) return (m_ptr + i) % N;
    end
    return -1;
  endfunction

  task automatic cycle(input logic [N-1:0] r, input logic [W-1:0] d = '0,
                       input bit use_d = 1'b0, input bit lk = 1'b0);
    int           g;
    logic [N-1:0] exp_gnt;
    @(negedge clk);
    req = r;
    for (int k = 0; k < N; k++) wdata[k*W +: W] = use_d ? d : $urandom;
`ifdef PRIM_FLOP_RR_WR_ARB_LOCK_EN
    lock = lk;
`endif
    #1;
    g = (m_hold > 0 || m_locked) ? -1 : pick(r);
    exp_gnt = '0;
    if (g >= 0) exp_gnt[g] = 1'b1;
    check("gnt", gnt, exp_gnt);
    check("busy", busy, m_hold > 0);
`ifdef PRIM_FLOP_RR_WR_ARB_LOCK_EN
    check("locked", locked, m_locked);
`endif
    if (g >= 0) begin
      sb_q.push_back('{g, wdata[g*W +: W]});
      m_ptr  = (g + 1) % N;
      m_hold = HOLD;
    end else if (m_hold > 0) begin
      m_hold--;
    end
    if (lk) m_locked = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    req   = 4'b1111;
    #1;
    check("rst_q", q, RST_VAL);
    check("rst_gnt", gnt, 0);
    check("rst_busy", busy, 0);
    check("rst_wr", wr, 0);
    check("rst_wr_idx", wr_idx, 0);
    m_ptr    = 0;
    m_hold   = 0;
    m_locked = 1'b0;
    m_q      = RST_VAL;
    sb_q.delete();
    @(negedge clk);
    #2;
    req   = '0;
    rst_n = 1'b1;
  endtask

  // Monitor: every write pulse must match the oldest expected write; otherwise
  // the register must hold its last committed value.
  always @(negedge clk) begin
    wr_t e;
    if (rst_n) begin
      if (wr) begin
        if (sb_q.size() == 0) begin
          check("wr_spurious", wr, 1'b0);
        end else begin
          e = sb_q.pop_front();
          check("wr_q", q, e.data);
          check("wr_idx", wr_idx, e.idx);
          m_q = e.data;
        end
      end else begin
        check("q_hold", q, m_q);
      end
    end
  end

  initial begin
    logic [N-1:0] r;

    do_reset();

    // Single write from requester 2, then the hold-off window.
    cycle(4'b0100, 32'hDEAD_BEEF, 1'b1);
    cycle(4'b0000);
    check("single_q", q, 32'hDEAD_BEEF);
    check("single_idx", wr_idx, 2);
    check("single_wr", wr, 1);
    repeat (3) cycle(4'b0000);

    // All requesters held: rotation from the updated pointer.
    repeat (16) cycle(4'b1111);

    // A held-off request that withdraws before its grant.
    cycle(4'b0001);
    cycle(4'b0010);
    cycle(4'b0000);
    repeat (3) cycle(4'b0000);

    // Reset in the middle of HOLD, then pointer back at 0.
    cycle(4'b0001);
    do_reset();
    cycle(4'b1010);
    check("post_rst_gnt", gnt, 4'b0010);
    repeat (3) cycle(4'b0000);

    // Randomized traffic with sticky requests and occasional resets.
    r = '0;
    for (int n = 0; n < 600; n++) begin
      for (int b = 0; b < N; b++) if ($urandom_range(0, 3) == 0) r[b] = ~r[b];
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
      end else begin
        cycle(r);
      end
    end
    repeat (HOLD + 2) cycle(4'b0000);

`ifdef PRIM_FLOP_RR_WR_ARB_LOCK_EN
    do_reset();
    cycle(4'b0001, 32'h1, 1'b1);
    cycle(4'b0000, '0, 1'b0, 1'b1);
    repeat (6) cycle(4'b0001, 32'h2, 1'b1);
    check("lock_q", q, 32'h1);
    check("lock_flag", locked, 1);
    do_reset();
    cycle(4'b0001, 32'h3, 1'b1);
    repeat (HOLD + 1) cycle(4'b0000);
`endif

    check("sb_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
